// File: rtl/univ_cnt_pkg.sv
// Shared encodings for the universal modulo counter family.
package univ_cnt_pkg;

  // Bound behaviour when a step crosses 0 or lim.
  typedef enum logic {
    CNT_WRAP = 1'b0,
    CNT_SAT  = 1'b1
  } cnt_mode_e;

  // Count direction.
  typedef enum logic {
    CNT_DN = 1'b0,
    CNT_UP = 1'b1
  } cnt_dir_e;

endpackage

// File: rtl/mod_step_calc.sv
// Combinational next-count calculator for one nonzero step within 0..lim.
// The effective step es is already clamped to lim+1 by the caller.
// Arithmetic is carried at N+1 bits so that lim = 2**N-1 cannot overflow.
module mod_step_calc
  import univ_cnt_pkg::*;
#(
  parameter int unsigned N = 8
) (
  input  logic [N-1:0] q,
  input  logic [N-1:0] lim,
  input  logic [N:0]   es,
  input  logic         up,
  input  logic         sat,
  output logic [N-1:0] q_next,
  output logic         evt
);

  localparam logic [N:0] ONE = (N+1)'(1);

  logic [N:0] q_w;
  logic [N:0] lim_w;
  logic [N:0] modulus;
  logic [N:0] t_up;

  // Widened operands shared by all branches.
  always_comb begin
    q_w     = {1'b0, q};
    lim_w   = {1'b0, lim};
    modulus = lim_w + ONE;
    t_up    = q_w + es;
  end

  // Select the next count and flag a bound crossing.
  always_comb begin
    q_next = q;
    evt    = 1'b0;
    if (q_w > lim_w) begin
      // Out-of-range count snaps back into range on any enabled step.
      evt = 1'b1;
      if (up == CNT_UP && sat == CNT_WRAP) q_next = '0;
      else                                 q_next = lim;
    end else if (up == CNT_UP) begin
      if (t_up <= lim_w) begin
        q_next = N'(t_up);
      end else begin
        evt = 1'b1;
        if (sat == CNT_SAT) q_next = lim;
        else                q_next = N'(t_up - modulus);
      end
    end else begin
      if (es <= q_w) begin
        q_next = N'(q_w - es);
      end else begin
        evt = 1'b1;
        if (sat == CNT_SAT) q_next = '0;
        else                q_next = N'(q_w + modulus - es);
      end
    end
  end

endmodule

// File: rtl/univ_mod_counter.sv
// Universal modulo counter: runtime limit and step, wrap or saturate,
// with clear/load/enable/up-down controls and a registered bound-crossing pulse.
module univ_mod_counter
  import univ_cnt_pkg::*;
#(
  parameter int unsigned N = 8,
  parameter int unsigned S = 4
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         syn_clr,
  input  logic         load,
  input  logic         en,
  input  logic         up,
  input  logic         sat,
  input  logic [N-1:0] lim,
  input  logic [S-1:0] step,
  input  logic [N-1:0] d,
  output logic [N-1:0] q,
  output logic         max_tick,
  output logic         min_tick,
  output logic         ovf_tick
);

  localparam logic [N:0] ONE = (N+1)'(1);

  logic [N:0]   step_w;
  logic [N:0]   modulus;
  logic [N:0]   es;
  logic [N-1:0] calc_q;
  logic         calc_evt;

  // Effective step: clamp to lim+1 so one step never spans more than a period.
  always_comb begin
    step_w  = {{(N+1-S){1'b0}}, step};
    modulus = {1'b0, lim} + ONE;
    es      = (step_w < modulus) ? step_w : modulus;
  end

  mod_step_calc #(
    .N(N)
  ) u_calc (
    .q      (q),
    .lim    (lim),
    .es     (es),
    .up     (up),
    .sat    (sat),
    .q_next (calc_q),
    .evt    (calc_evt)
  );

  // Count register with clear > load > enabled step > hold priority.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q        <= '0;
      ovf_tick <= 1'b0;
    end else if (syn_clr) begin
      q        <= '0;
      ovf_tick <= 1'b0;
    end else if (load) begin
      q        <= d;
      ovf_tick <= 1'b0;
    end else if (en && (es != '0)) begin
      q        <= calc_q;
      ovf_tick <= calc_evt;
    end else begin
      ovf_tick <= 1'b0;
    end
  end

  // Bound indicators decoded straight from the count.
  always_comb begin
    max_tick = (q == lim);
    min_tick = (q == '0);
  end

endmodule

// File: tb/tb_univ_mod_counter.sv
// Directed, table-driven bench for univ_mod_counter (N=8, S=4).
module tb_univ_mod_counter;

  logic       clk;
  logic       reset_n;
  logic       syn_clr;
  logic       load;
  logic       en;
  logic       up;
  logic       sat;
  logic [7:0] lim;
  logic [3:0] step;
  logic [7:0] d;
  logic [7:0] q;
  logic       max_tick;
  logic       min_tick;
  logic       ovf_tick;

  int unsigned n_chk;
  int unsigned n_fail;

  typedef struct {
    logic       c;
    logic       l;
    logic       e;
    logic       u;
    logic       s;
    logic [7:0] lim;
    logic [3:0] st;
    logic [7:0] d;
    logic [7:0] eq;
    logic       eo;
    logic       emx;
    logic       emn;
  } vec_t;

  vec_t vec[64];
  int   nv;

  univ_mod_counter #(
    .N(8),
    .S(4)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .syn_clr  (syn_clr),
    .load     (load),
    .en       (en),
    .up       (up),
    .sat      (sat),
    .lim      (lim),
    .step     (step),
    .d        (d),
    .q        (q),
    .max_tick (max_tick),
    .min_tick (min_tick),
    .ovf_tick (ovf_tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic add(input logic c, input logic l, input logic e, input logic u,
                     input logic s, input logic [7:0] lm, input logic [3:0] st,
                     input logic [7:0] dd, input logic [7:0] eq, input logic eo,
                     input logic emx, input logic emn);
    vec[nv] = '{c, l, e, u, s, lm, st, dd, eq, eo, emx, emn};
    nv++;
  endtask

  task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic drive(input logic c, input logic l, input logic e, input logic u,
                       input logic s, input logic [7:0] lm, input logic [3:0] st,
                       input logic [7:0] dd);
    syn_clr = c; load = l; en = e; up = u; sat = s; lim = lm; step = st; d = dd;
  endtask

  initial begin
    n_chk = 0;
    n_fail = 0;
    nv = 0;
    drive(0, 0, 0, 1, 0, 8'd9, 4'd3, 8'd0);
    reset_n = 1'b0;

    // c l e u s  lim  st  d     q    ovf max min
    // Wrap up, lim=9 step=3 from reset
    add(0,0,1,1,0, 8'd9,  4'd3, 8'd0,   8'd3,   0,0,0);
    add(0,0,1,1,0, 8'd9,  4'd3, 8'd0,   8'd6,   0,0,0);
    add(0,0,1,1,0, 8'd9,  4'd3, 8'd0,   8'd9,   0,1,0);
    add(0,0,1,1,0, 8'd9,  4'd3, 8'd0,   8'd2,   1,0,0);
    add(0,0,1,1,0, 8'd9,  4'd3, 8'd0,   8'd5,   0,0,0);
    add(0,0,1,1,0, 8'd9,  4'd3, 8'd0,   8'd8,   0,0,0);
    add(0,0,1,1,0, 8'd9,  4'd3, 8'd0,   8'd1,   1,0,0);
    // Saturate down, lim=20 from 5 step 2
    add(0,1,0,0,1, 8'd20, 4'd2, 8'd5,   8'd5,   0,0,0);
    add(0,0,1,0,1, 8'd20, 4'd2, 8'd0,   8'd3,   0,0,0);
    add(0,0,1,0,1, 8'd20, 4'd2, 8'd0,   8'd1,   0,0,0);
    add(0,0,1,0,1, 8'd20, 4'd2, 8'd0,   8'd0,   1,0,1);
    add(0,0,1,0,1, 8'd20, 4'd2, 8'd0,   8'd0,   1,0,1);
    add(0,0,1,0,1, 8'd20, 4'd2, 8'd0,   8'd0,   1,0,1);
    add(0,0,0,0,1, 8'd20, 4'd2, 8'd0,   8'd0,   0,0,1);
    // Out-of-range load, lim=10
    add(0,1,0,1,0, 8'd10, 4'd1, 8'd200, 8'd200, 0,0,0);
    add(0,0,1,1,0, 8'd10, 4'd1, 8'd0,   8'd0,   1,0,1);
    add(0,1,0,1,1, 8'd10, 4'd1, 8'd200, 8'd200, 0,0,0);
    add(0,0,1,1,1, 8'd10, 4'd1, 8'd0,   8'd10,  1,1,0);
    add(0,1,0,0,0, 8'd10, 4'd1, 8'd200, 8'd200, 0,0,0);
    add(0,0,1,0,0, 8'd10, 4'd1, 8'd0,   8'd10,  1,1,0);
    // Priority
    add(0,1,0,1,0, 8'd10, 4'd1, 8'd4,   8'd4,   0,0,0);
    add(1,1,1,1,0, 8'd10, 4'd1, 8'd7,   8'd0,   0,0,1);
    add(0,1,1,1,0, 8'd10, 4'd1, 8'd7,   8'd7,   0,0,0);
    // Full-width legacy
    add(0,1,0,1,0, 8'd255,4'd1, 8'd254, 8'd254, 0,0,0);
    add(0,0,1,1,0, 8'd255,4'd1, 8'd0,   8'd255, 0,1,0);
    add(0,0,1,1,0, 8'd255,4'd1, 8'd0,   8'd0,   1,0,1);
    add(0,1,0,1,0, 8'd255,4'd15,8'd250, 8'd250, 0,0,0);
    add(0,0,1,1,0, 8'd255,4'd15,8'd0,   8'd9,   1,0,0);
    // Hold on en=0 and on step=0
    add(0,0,0,1,0, 8'd255,4'd15,8'd0,   8'd9,   0,0,0);
    add(0,0,1,1,0, 8'd255,4'd0, 8'd0,   8'd9,   0,0,0);
    // lim=0: range {0}
    add(1,0,0,1,0, 8'd0,  4'd5, 8'd0,   8'd0,   0,1,1);
    add(0,0,1,1,0, 8'd0,  4'd5, 8'd0,   8'd0,   1,1,1);
    add(0,0,1,0,1, 8'd0,  4'd5, 8'd0,   8'd0,   1,1,1);
    // Step larger than modulus is clamped to lim+1
    add(0,1,0,1,0, 8'd3,  4'd7, 8'd2,   8'd2,   0,0,0);
    add(0,0,1,1,0, 8'd3,  4'd7, 8'd0,   8'd2,   1,0,0);
    add(0,0,1,0,0, 8'd3,  4'd7, 8'd0,   8'd2,   1,0,0);
    // Down wrap
    add(0,1,0,0,0, 8'd9,  4'd3, 8'd1,   8'd1,   0,0,0);
    add(0,0,1,0,0, 8'd9,  4'd3, 8'd0,   8'd8,   1,0,0);
    // Saturate up pinned at lim
    add(0,1,0,1,1, 8'd9,  4'd3, 8'd8,   8'd8,   0,0,0);
    add(0,0,1,1,1, 8'd9,  4'd3, 8'd0,   8'd9,   1,1,0);
    add(0,0,1,1,1, 8'd9,  4'd3, 8'd0,   8'd9,   1,1,0);

    #12;
    chk8("reset q", q, 8'd0);
    chk1("reset ovf", ovf_tick, 1'b0);
    chk1("reset min", min_tick, 1'b1);
    @(negedge clk);
    reset_n = 1'b1;

    for (int i = 0; i < nv; i++) begin
      @(negedge clk);
      drive(vec[i].c, vec[i].l, vec[i].e, vec[i].u, vec[i].s, vec[i].lim, vec[i].st, vec[i].d);
      @(posedge clk);
      #1;
      chk8($sformatf("v%0d q", i), q, vec[i].eq);
      chk1($sformatf("v%0d ovf", i), ovf_tick, vec[i].eo);
      chk1($sformatf("v%0d max", i), max_tick, vec[i].emx);
      chk1($sformatf("v%0d min", i), min_tick, vec[i].emn);
    end

    // Async reset mid-count with a pending event: 1 - 5 wraps to 6 in lim=9
    @(negedge clk);
    drive(0, 1, 0, 0, 0, 8'd9, 4'd5, 8'd1);
    @(negedge clk);
    drive(0, 0, 1, 0, 0, 8'd9, 4'd5, 8'd0);
    @(posedge clk);
    #1;
    chk8("pre-reset q", q, 8'd6);
    chk1("pre-reset ovf", ovf_tick, 1'b1);
    #1;
    reset_n = 1'b0;
    #1;
    chk8("async reset q", q, 8'd0);
    chk1("async reset ovf", ovf_tick, 1'b0);
    drive(0, 0, 1, 1, 0, 8'd9, 4'd3, 8'd0);
    @(negedge clk);
    chk8("reset held q", q, 8'd0);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    chk8("resume q", q, 8'd3);
    chk1("resume ovf", ovf_tick, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
